servo_pwm_driver: RTL and testbench

//  Downstream of the button-driven 11-bit position counter: converts the position word into a

---
 rtl/servo_pkg.sv | 20 ++
 rtl/servo_slew_limiter.sv | 30 +++
 rtl/servo_pwm_driver.sv | 113 +++++++++++
 tb/tb_servo_pwm_driver.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared constants and FSM encoding for the servo PWM joint drivers.
// Defaults give 1 us ticks, a 20 ms frame and a 1..2 ms pulse.
package servo_pkg;

  localparam int POS_W         = 11;
  localparam int CNT_W         = 15;
  localparam int PROD_W        = 27;
  localparam int PERIOD_DEF    = 20000;
  localparam int MIN_PULSE_DEF = 1000;
  localparam int MAX_PULSE_DEF = 2000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CALC = 3'd2,
    HIGH = 3'd3,
    LOW  = 3'd4
  } state_e;

endpackage

// File: rtl/servo_slew_limiter.sv
// Combinational per-frame slew step: moves cur toward tgt by at most STEP.
// Compares run one bit wider so cur+STEP never wraps.
module servo_slew_limiter
  import servo_pkg::*;
#(
  parameter int STEP = 16
) (
  input  logic [POS_W-1:0] cur_i,
  input  logic [POS_W-1:0] tgt_i,
  output logic [POS_W-1:0] nxt_o
);

  localparam logic [POS_W:0] STEP_X = (POS_W+1)'(STEP);

  logic [POS_W:0] cur_x;
  logic [POS_W:0] tgt_x;

  assign cur_x = {1'b0, cur_i};
  assign tgt_x = {1'b0, tgt_i};

  always_comb begin
    nxt_o = tgt_i;
    if (tgt_x > cur_x + STEP_X) begin
      nxt_o = cur_i + STEP_X[POS_W-1:0];
    end else if (tgt_x + STEP_X < cur_x) begin
      nxt_o = cur_i - STEP_X[POS_W-1:0];
    end
  end

endmodule

// File: rtl/servo_pwm_driver.sv
// Hobby-servo PWM generator with per-frame slew limiting.
// Frame = LOAD + CALC + HIGH(width) + LOW, exactly PERIOD clkout ticks.
module servo_pwm_driver
  import servo_pkg::*;
#(
  parameter int PERIOD    = PERIOD_DEF,
  parameter int MIN_PULSE = MIN_PULSE_DEF,
  parameter int MAX_PULSE = MAX_PULSE_DEF,
  parameter int STEP      = 16
) (
  input  logic             clkout,
  input  logic             rst,
  input  logic             en,
  input  logic [POS_W-1:0] pos_in,
  output logic             pwm,
  output logic             frame_tick,
  output logic [POS_W-1:0] cur_pos,
  output logic             at_target
);

  localparam logic [CNT_W-1:0]  PER_M1 = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]  MIN_W  = CNT_W'(MIN_PULSE);
  localparam logic [PROD_W-1:0] SPAN   = PROD_W'(MAX_PULSE - MIN_PULSE);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   pcnt_q, pcnt_d;
  logic [CNT_W-1:0]   width_q, width_d;
  logic [POS_W-1:0]   cur_q, cur_d;
  logic [POS_W-1:0]   tgt_q, tgt_d;
  logic               at_q, at_d;
  logic [POS_W-1:0]   slew_nxt;
  logic [PROD_W-1:0]  prod;
  logic [CNT_W-1:0]   width_calc;

  servo_slew_limiter #(
    .STEP (STEP)
  ) u_slew (
    .cur_i (cur_q),
    .tgt_i (pos_in),
    .nxt_o (slew_nxt)
  );

  assign prod       = PROD_W'(cur_q) * SPAN;
  assign width_calc = MIN_W + CNT_W'(prod >> POS_W);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    pcnt_d  = pcnt_q;
    width_d = width_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = LOAD;
          cnt_d   = '0;
        end
        LOAD: begin
          tgt_d   = pos_in;
          cur_d   = slew_nxt;
          state_d = CALC;
        end
        CALC: begin
          width_d = width_calc;
          pcnt_d  = '0;
          state_d = HIGH;
        end
        HIGH: begin
          pcnt_d = pcnt_q + 1'b1;
          if (pcnt_q == width_q - 1'b1) state_d = LOW;
        end
        LOW: begin
          if (cnt_q == PER_M1) begin
            state_d = LOAD;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    at_d = (cur_d == tgt_d);
  end

  always_ff @(posedge clkout) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      width_q <= MIN_W;
      cur_q   <= '0;
      tgt_q   <= '0;
      at_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      width_q <= width_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      at_q    <= at_d;
    end
  end

  assign pwm        = (state_q == HIGH);
  assign frame_tick = (state_q == LOAD);
  assign cur_pos    = cur_q;
  assign at_target  = at_q;

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Directed bench: fast-slew (STEP=2047) and slow-slew (STEP=64) joints.
// Short frame keeps runtime low; pulse widths match the default scaling.
module tb_servo_pwm_driver;

  localparam int PER = 2050;

  logic        clk = 1'b0;
  logic        rst_f, rst_s, en;
  logic [10:0] pos;
  logic        pwm_f, ft_f, at_f;
  logic        pwm_s, ft_s, at_s;
  logic [10:0] cur_f, cur_s;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  servo_pwm_driver #(
    .PERIOD (PER), .MIN_PULSE (1000), .MAX_PULSE (2000), .STEP (2047)
  ) u_fast (
    .clkout (clk), .rst (rst_f), .en (en), .pos_in (pos),
    .pwm (pwm_f), .frame_tick (ft_f), .cur_pos (cur_f), .at_target (at_f)
  );

  servo_pwm_driver #(
    .PERIOD (PER), .MIN_PULSE (1000), .MAX_PULSE (2000), .STEP (64)
  ) u_slow (
    .clkout (clk), .rst (rst_s), .en (en), .pos_in (pos),
    .pwm (pwm_s), .frame_tick (ft_s), .cur_pos (cur_s), .at_target (at_s)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Cycles until the next frame_tick; -1 if none within 3 frames.
  task automatic wait_tick(input bit s, output int n);
    bit done = 1'b0;
    n = 0;
    while (!done && n < 3 * PER) begin
      @(negedge clk);
      n++;
      if (s ? ft_s : ft_f) done = 1'b1;
    end
    if (!done) n = -1;
  endtask

  // Length of the next pwm pulse; optional pos change after poke high cycles.
  task automatic pulse(input bit s, input int poke, input logic [10:0] pv,
                       output int len);
    int w = 0;
    len = 0;
    while (!(s ? pwm_s : pwm_f) && w < PER) begin
      @(negedge clk);
      w++;
    end
    if (w >= PER) begin
      len = -1;
    end else begin
      while ((s ? pwm_s : pwm_f) && len < PER) begin
        if (len == poke) pos = pv;
        @(negedge clk);
        len++;
      end
    end
  endtask

  initial begin
    int n;
    int len;
    int cnt;
    rst_f = 1'b1;
    rst_s = 1'b1;
    en    = 1'b0;
    pos   = '0;
    repeat (3) @(negedge clk);
    chk("rst_pwm", pwm_f, 0);
    chk("rst_tick", ft_f, 0);
    chk("rst_cur", cur_f, 0);
    chk("rst_at", at_f, 1);

    rst_f = 1'b0;
    en    = 1'b1;
    wait_tick(0, n);
    chk("t1_first_tick", n, 1);
    pulse(0, -1, '0, len);
    chk("t1_width0", len, 1000);
    wait_tick(0, n);
    wait_tick(0, n);
    chk("t1_period", n, PER);

    pulse(0, -1, '0, len);
    pos = 11'd2047;
    wait_tick(0, n);
    chk("t2_cur_before", cur_f, 0);
    @(negedge clk);
    chk("t2_cur_after", cur_f, 2047);
    chk("t2_at", at_f, 1);
    pulse(0, -1, '0, len);
    chk("t2_width_max", len, 1999);

    pos = '0;
    wait_tick(0, n);
    pulse(0, 10, 11'd2047, len);
    chk("t4_cur_pulse", len, 1000);
    chk("t4_cur_pos", cur_f, 0);
    wait_tick(0, n);
    pulse(0, -1, '0, len);
    chk("t4_next_pulse", len, 1999);

    wait_tick(0, n);
    pulse(0, 5, 11'd2047, len);
    wait_tick(0, n);
    n = 0;
    while (!pwm_f && n < PER) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("t5_pwm_off", pwm_f, 0);
    cnt = 0;
    for (int i = 0; i < PER + 100; i++) begin
      @(negedge clk);
      if (ft_f || pwm_f) cnt++;
    end
    chk("t5_quiet", cnt, 0);
    chk("t5_cur_kept", cur_f, 2047);
    en = 1'b1;
    @(negedge clk);
    chk("t5_reload", ft_f, 1);
    chk("t5_cur_same", cur_f, 2047);
    pulse(0, -1, '0, len);
    chk("t5_fresh_pulse", len, 1999);

    pos = 11'd500;
    wait_tick(0, n);
    pulse(0, -1, '0, len);
    chk("t6_width500", len, 1244);
    @(negedge clk);
    chk("t6_cur500", cur_f, 500);
    rst_f = 1'b1;
    @(negedge clk);
    chk("t6_cur0", cur_f, 0);
    chk("t6_pwm0", pwm_f, 0);
    chk("t6_at1", at_f, 1);
    chk("t6_tick0", ft_f, 0);
    repeat (2) @(negedge clk);
    chk("t6_rst_wins", ft_f, 0);
    rst_f = 1'b0;
    @(negedge clk);
    chk("t6_restart", ft_f, 1);

    pos   = 11'd1024;
    rst_s = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      wait_tick(1, n);
      @(negedge clk);
      chk($sformatf("t3_cur_%0d", k), cur_s, 64 * k);
      chk($sformatf("t3_at_%0d", k), at_s, (k == 16) ? 1 : 0);
      if (k == 1) begin
        pulse(1, -1, '0, len);
        chk("t3_width64", len, 1031);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
